// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit width and the saturation limit helper.
package bin2bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic int max_val(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_nib,
    output logic [BCD_W-1:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) o_nib = i_nib + 4'd3;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter with a start/done handshake.
// One bit is shifted per clock; values above the decimal range saturate to all nines.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int                  MAX_VAL  = max_val(DIGITS);
    localparam int                  ACC_W    = BCD_W * DIGITS;
    localparam int                  CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [31:0]         MAX_U    = 32'(MAX_VAL);
    localparam logic [ACC_W-1:0]    BCD_SAT  = {DIGITS{4'h9}};

    state_t                         r_state;
    logic [DIGITS-1:0][BCD_W-1:0]   r_acc;
    logic [BIN_W-1:0]               r_sr;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_ovf_pend;
    logic                           r_busy;
    logic                           r_done;
    logic [ACC_W-1:0]               r_bcd;
    logic                           r_ovf;

    logic [DIGITS-1:0][BCD_W-1:0]   w_adj;
    logic [ACC_W+BIN_W-1:0]         w_shift;
    logic [31:0]                    w_bin_ext;
    logic                           w_bin_ovf;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .i_nib (r_acc[g]),
                .o_nib (w_adj[g])
            );
        end
    endgenerate

    // Carries out of the top digit fall off the end; out-of-range inputs are
    // handled by saturation instead.
    assign w_shift   = {w_adj, r_sr} << 1;
    assign w_bin_ext = 32'(bin);
    assign w_bin_ovf = (w_bin_ext > MAX_U);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr       <= bin;
                        r_ovf_pend <= w_bin_ovf;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_shift[ACC_W+BIN_W-1:BIN_W];
                    r_sr  <= w_shift[BIN_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Last shift: publish the freshly shifted accumulator directly.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bcd   <= r_ovf_pend ? BCD_SAT : w_shift[ACC_W+BIN_W-1:BIN_W];
                        r_ovf   <= r_ovf_pend;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, hold, saturation, handshake, reset and streaming.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int checks;
    int failures;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Starts one conversion from an IDLE negedge and returns at the following IDLE negedge.
    task automatic run_conv(input logic [13:0] v, output int lat, output int nbusy,
                            output logic held, output logic got);
        logic [15:0] prev;
        prev  = bcd;
        held  = 1'b1;
        lat   = 0;
        nbusy = 0;
        got   = 1'b0;
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 1; s <= 40 && !got; s++) begin
            if (done) begin
                got = 1'b1;
                lat = s;
            end else begin
                if (busy) nbusy++;
                if (bcd !== prev) held = 1'b0;
                @(negedge clk);
            end
        end
        if (got) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat, nb;
        logic held, got;
        run_conv(14'd0, lat, nb, held, got);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL zero_timeout got=%b exp=1", got); end
        checks++; if (lat != 15) begin failures++; $display("FAIL zero_latency got=%0d exp=15", lat); end
        checks++; if (nb != 14) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=14", nb); end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL zero_bcd got=%h exp=0000", bcd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL zero_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_hold();
        int lat, nb;
        logic held, got;
        run_conv(14'd1597, lat, nb, held, got);
        checks++; if (!got || bcd !== 16'h1597) begin failures++; $display("FAIL conv_1597 got=%h exp=1597", bcd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_1597 got=%b exp=0", overflow); end
        run_conv(14'd987, lat, nb, held, got);
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL hold_1597 got=changed exp=held"); end
        checks++; if (!got || bcd !== 16'h0987) begin failures++; $display("FAIL conv_987 got=%h exp=0987", bcd); end
    endtask

    task automatic test_overflow();
        int lat, nb;
        logic held, got;
        run_conv(14'd9999, lat, nb, held, got);
        checks++; if (!got || bcd !== 16'h9999) begin failures++; $display("FAIL conv_9999 got=%h exp=9999", bcd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_9999 got=%b exp=0", overflow); end
        run_conv(14'd10000, lat, nb, held, got);
        checks++; if (!got || bcd !== 16'h9999) begin failures++; $display("FAIL conv_10000 got=%h exp=9999", bcd); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_10000 got=%b exp=1", overflow); end
        run_conv(14'd16383, lat, nb, held, got);
        checks++; if (!got || bcd !== 16'h9999) begin failures++; $display("FAIL conv_16383 got=%h exp=9999", bcd); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_16383 got=%b exp=1", overflow); end
    endtask

    task automatic test_ignore();
        int ndone, done_s, lat, nb;
        logic held, got, repulse;
        ndone   = 0;
        done_s  = 0;
        repulse = 1'b0;
        bin     = 14'd4181;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 1; s <= 24; s++) begin
            if (repulse) begin
                start   = 1'b0;
                repulse = 1'b0;
            end
            if (s == 3) begin
                start = 1'b1;
                bin   = 14'd6765;
            end else if (s == 4) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                done_s = s;
                checks++; if (bcd !== 16'h4181) begin failures++; $display("FAIL ignore_bcd got=%h exp=4181", bcd); end
                start   = 1'b1;
                bin     = 14'd6765;
                repulse = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        checks++; if (done_s != 15) begin failures++; $display("FAIL ignore_done_cycle got=%0d exp=15", done_s); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle_busy got=%b exp=0", busy); end
        run_conv(14'd6765, lat, nb, held, got);
        checks++; if (!got || bcd !== 16'h6765) begin failures++; $display("FAIL conv_6765 got=%h exp=6765", bcd); end
    endtask

    task automatic test_reset_mid();
        int ndone, lat, nb;
        logic held, got;
        ndone = 0;
        bin   = 14'd2584;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_inflight got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL midreset_bcd got=%h exp=0000", bcd); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
        run_conv(14'd2584, lat, nb, held, got);
        checks++; if (!got || bcd !== 16'h2584) begin failures++; $display("FAIL conv_2584 got=%h exp=2584", bcd); end
    endtask

    task automatic test_back_to_back();
        int v, last_s;
        v      = 0;
        last_s = 0;
        bin    = 14'd0;
        start  = 1'b1;
        for (int s = 1; s <= 400 && v <= 20; s++) begin
            @(negedge clk);
            if (done) begin
                checks++; if (bcd !== to_bcd(v)) begin failures++; $display("FAIL b2b_bcd v=%0d got=%h exp=%h", v, bcd, to_bcd(v)); end
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf v=%0d got=%b exp=0", v, overflow); end
                if (v > 0) begin
                    checks++; if (s - last_s != 16) begin failures++; $display("FAIL b2b_period v=%0d got=%0d exp=16", v, s - last_s); end
                end
                last_s = s;
                v++;
                bin = 14'(v);
            end
        end
        start = 1'b0;
        checks++; if (v != 21) begin failures++; $display("FAIL b2b_timeout got=%0d exp=21", v); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        bin      = '0;
        test_reset();
        test_zero();
        test_hold();
        test_overflow();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the per-digit 7-segment decoders.
- Takes a binary term from the Fibonacci generator and produces packed BCD digits, thousands digit first.
- Replaces the combinational /10 and %10 arithmetic with an area-cheap multi-cycle datapath and a start/done handshake.

Parameters:
- BIN_W, 14: width of the binary input.
- DIGITS, 4: number of BCD output digits.
- MAX_VAL, 9999: largest representable value, 10^DIGITS-1. Derived; not overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- start  input  1  request a conversion of bin. Sampled on the rising edge of clk.
- bin  input  BIN_W  unsigned binary value. Captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that bcd and overflow are updated.
- bcd  output  4*DIGITS  packed BCD. [15:12]=thousands, [11:8]=hundreds, [7:4]=tens, [3:0]=units.
- overflow  output  1  high when the last converted bin exceeded MAX_VAL.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, bcd=0, overflow=0.
  - Internal shift register and counter cleared.
  - Any conversion in flight is abandoned; no done pulse is produced.
- States: IDLE, CONV, DONE.
- IDLE:
  - start=1 at an edge: capture bin into the shift register, capture (bin>MAX_VAL) into an internal flag, clear the BCD accumulator, set count=0, go to CONV.
  - busy=1 from the cycle after the accepting edge.
- CONV, one iteration per edge:
  - Every BCD nibble >=5 gets +3 (combinational).
  - Then {bcd_acc, bin_sr} shifts left by 1; count increments.
  - On the edge where count reaches BIN_W-1 (the BIN_W-th shift), go to DONE and register the outputs:
    - internal flag=0: bcd=final accumulator.
    - internal flag=1: bcd=all digits 9 (16'h9999, saturation).
    - overflow=internal flag.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
- Latency:
  - Start accepted at edge k; bcd valid and done=1 in the cycle following edge k+BIN_W (14 edges at default).
  - Back-to-back throughput is one conversion per BIN_W+2 cycles.
- Handshake rules:
  - start while busy=1 (CONV) is ignored. bin changes during CONV have no effect.
  - start during the DONE cycle is ignored. It must be re-asserted in IDLE.
  - start held high continuously begins a new conversion on each IDLE edge.
- Output hold: bcd and overflow hold their last values between done pulses, including through the next conversion until its done.
- Width rules:
  - Accumulator is 4*DIGITS bits.
  - Bits shifted out of the accumulator MSB are discarded. Correctness for bin>MAX_VAL comes solely from saturation.
  - Counter width is clog2(BIN_W).
- Every nibble of bcd is always in 0..9, so downstream decoders never see 10..15.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, CONV, DONE}.
  - BCD_W=4.
  - function max_val(DIGITS) returning 10^DIGITS-1.
- One natural sub-module: bcd_add3, combinational 4-bit "if >=5 add 3", instantiated DIGITS times by generate.

Test Plan:
- bin=0, start pulse -> done after 14 edges; bcd=16'h0000, overflow=0; busy high exactly 14 cycles.
- bin=1597 -> bcd=16'h1597, overflow=0. Then bin=987 -> bcd=16'h0987. bcd holds 16'h1597 until the second done.
- bin=9999 -> bcd=16'h9999, overflow=0. Then bin=10000 -> bcd=16'h9999, overflow=1. Then bin=16383 -> bcd=16'h9999, overflow=1.
- Start with bin=4181. Re-pulse start with bin=6765 at cycles 3 and 15 (DONE) -> single done, bcd=16'h4181. Next IDLE start converts 6765.
- Drop reset to 0 at cycle 7 of converting 2584 -> busy=0, bcd=0 immediately. No done pulse. After release, bin=2584 -> bcd=16'h2584.
- start held high with bin=0..20 stepping each done -> every result matches the decimal value; period exactly 16 cycles.
